mycpu_muldiv: RTL

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the single-cycle ALU in the execute stage of the myCPU pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests over a valid/ready handshake. Products and quotients are computed iteratively, one bit per cycle. Completion is signalled with a one-cycle done pulse, and an exception flush can abort an in-flight operation.

---
 rtl/mycpu_muldiv_pkg.sv | 24 ++
 rtl/mycpu_muldiv_step.sv | 45 ++++
 rtl/mycpu_muldiv.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mycpu_muldiv_pkg.sv
// Shared definitions for the myCPU multiply/divide unit:
// operation codes, FSM encoding and a small decode helper.
package mycpu_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic op_is_signed(
    input logic [2:0] op
  );
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mycpu_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// Accumulator layout: {upper half, lower half}, 2*DATA_WIDTH bits.
import mycpu_muldiv_pkg::*;

module mycpu_muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      mul_mode,
  input  logic [2*DATA_WIDTH-1:0]   acc,
  input  logic [DATA_WIDTH-1:0]     opnd,
  output logic [2*DATA_WIDTH-1:0]   acc_next,
  output logic                      q_bit
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   add_sum;
  logic [W:0]   rem_sh;
  logic [W:0]   diff;
  logic [W-1:0] addend;
  logic [W-1:0] rem_new;

  // Multiply: add opnd when the current multiplier bit is set, then
  // shift right. Divide: shift in the next dividend bit, try-subtract.
  // For divide the quotient bit is returned separately, LSB left 0.
  always_comb begin
    addend   = acc[0] ? opnd : {W{1'b0}};
    add_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, addend};
    rem_sh   = acc[2*W-1:W-1];
    diff     = rem_sh - {1'b0, opnd};
    rem_new  = rem_sh[W-1:0];
    q_bit    = 1'b0;
    acc_next = '0;
    if (mul_mode) begin
      acc_next = {add_sum, acc[W-1:1]};
    end else begin
      q_bit = ~diff[W];
      if (q_bit) begin
        rem_new = diff[W-1:0];
      end
      acc_next = {rem_new, acc[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mycpu_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers for the
// myCPU execute stage; one bit per cycle, sign fix-up at the end.
import mycpu_muldiv_pkg::*;

module mycpu_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(DATA_WIDTH - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2*W-1:0]       acc;
  logic [W-1:0]         opnd;
  logic [W-1:0]         a_raw;
  logic                 is_mul;
  logic                 sign_q;
  logic                 sign_r;
  logic                 div_zero;

  logic [2*W-1:0]       step_acc;
  logic                 step_q;
  logic                 op_sgn;
  logic                 op_mul;
  logic                 op_div;
  logic [W-1:0]         abs_a;
  logic [W-1:0]         abs_b;
  logic [2*W-1:0]       prod_fix;
  logic [W-1:0]         quo_fix;
  logic [W-1:0]         rem_fix;

  mycpu_muldiv_step #(
    .DATA_WIDTH(W)
  ) u_step (
    .mul_mode (is_mul),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state == CALC) || (state == FIX);

  // Request decode and operand magnitudes for signed ops.
  always_comb begin
    op_sgn = op_is_signed(req_op);
    op_mul = (req_op == OP_MULT) || (req_op == OP_MULTU);
    op_div = (req_op == OP_DIV) || (req_op == OP_DIVU);
    abs_a  = (op_sgn && req_a[W-1]) ? -req_a : req_a;
    abs_b  = (op_sgn && req_b[W-1]) ? -req_b : req_b;
  end

  // Final sign correction of product, quotient and remainder.
  always_comb begin
    prod_fix = sign_q ? -acc : acc;
    quo_fix  = sign_q ? -acc[W-1:0] : acc[W-1:0];
    rem_fix  = sign_r ? -acc[2*W-1:W] : acc[2*W-1:W];
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_mul   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && !cancel) begin
            if (op_mul || op_div) begin
              state    <= CALC;
              cnt      <= '0;
              is_mul   <= op_mul;
              sign_q   <= op_sgn & (req_a[W-1] ^ req_b[W-1]);
              sign_r   <= op_sgn & req_a[W-1];
              div_zero <= (req_b == '0);
              a_raw    <= req_a;
              if (op_mul) begin
                acc  <= {{W{1'b0}}, abs_b};
                opnd <= abs_a;
              end else begin
                acc  <= {{W{1'b0}}, abs_a};
                opnd <= abs_b;
              end
            end else if (req_op == OP_MTHI) begin
              hi <= req_a;
            end else if (req_op == OP_MTLO) begin
              lo <= req_a;
            end
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            if (is_mul) begin
              acc <= step_acc;
            end else begin
              acc <= {step_acc[2*W-1:1], step_q};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          state <= IDLE;
          cnt   <= '0;
          if (!cancel) begin
            done <= 1'b1;
            if (is_mul) begin
              {hi, lo} <= prod_fix;
            end else if (div_zero) begin
              lo <= '1;
              hi <= a_raw;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
